// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
//
// Purpose: bridges the single-cycle core datapath to a shared word-wide
// data-memory bus. It places byte/halfword store data on the correct lanes,
// runs a req/gnt/rvalid handshake, and returns sign- or zero-extended load
// data. The core is stalled until the access completes. Misaligned or
// illegal requests are reported combinationally, and bus timeouts are
// reported for one cycle.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   MemRead, MemWrite       load / store request from the core
//   Funct3[2:0]             000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResult[31:0]         byte address
//   WriteData[31:0]         store data, valid bytes in the low lanes
//   ReadData[31:0]          registered, extended load result
//   Stall                   core holds PC/instruction/write-enable while high
//   AccessFault             misaligned, illegal Funct3, or read & write together
//   BusError                wait limit exceeded; high in the DONE cycle only
//   bus_req/we/addr/be/wdata  captured request presented to the bus
//   bus_gnt, bus_rvalid, bus_rdata  bus slave responses
module load_store_unit #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AccessFault,
   output logic        BusError,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   // Counter holds the number of REQ/WAIT cycles already completed, so the
   // last permitted cycle is the one where it equals WAIT_LIMIT-1.
   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_read_data;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [7:0]  r_cnt;
   logic        r_bus_error;

   logic        w_access;
   logic        w_bad_f3;
   logic        w_misalign;
   logic        w_fault_cond;
   logic        w_accept;
   logic        w_timeout;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_lane;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;

   assign w_access = MemRead | MemWrite;
   assign w_off    = ALUResult[1:0];

   // Store codes with Funct3[2] set are unsigned-load encodings, so they
   // are illegal for stores.
   assign w_bad_f3     = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) ||
                         (MemWrite && Funct3[2]);
   assign w_misalign   = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                         ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
   assign w_fault_cond = (MemRead & MemWrite) | w_bad_f3 | w_misalign;
   assign w_accept     = (r_state == S_IDLE) && w_access && !w_fault_cond;

   // Byte enables follow the access size for loads and stores alike.
   always_comb begin
      w_be = 4'b1111;
      case (Funct3[1:0])
         2'b00:   w_be = 4'b0001 << w_off;
         2'b01:   w_be = 4'b0011 << w_off;
         default: w_be = 4'b1111;
      endcase
   end

   // Replicate the low byte/halfword across every lane so the slave can
   // pick it up from whichever lane the byte enables select.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[8*gi +: 8] = (Funct3[1:0] == 2'b00) ? WriteData[7:0] :
                                 (Funct3[1:0] == 2'b01) ? WriteData[8*(gi%2) +: 8] :
                                                          WriteData[8*gi +: 8];
   end
   assign w_wdata = MemWrite ? w_lane : 32'h0;

   // Load extraction uses the captured size and offset, not the live inputs.
   assign w_shifted = bus_rdata >> {r_off, 3'b000};
   always_comb begin
      w_load_data = bus_rdata;
      case (r_f3)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
         default: w_load_data = bus_rdata;
      endcase
   end

   // Next-state logic. The exit event wins over the timeout when both land
   // on the last permitted cycle.
   always_comb begin
      w_state_next = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_REQ;
         end
         S_REQ: begin
            if (bus_gnt) begin
               w_state_next = r_we ? S_DONE : S_WAIT;
            end else if (r_cnt == LIMIT_M1) begin
               w_state_next = S_DONE;
               w_timeout    = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus_rvalid) begin
               w_state_next = S_DONE;
            end else if (r_cnt == LIMIT_M1) begin
               w_state_next = S_DONE;
               w_timeout    = 1'b1;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_read_data <= 32'h0;
         r_we        <= 1'b0;
         r_addr      <= 32'h0;
         r_be        <= 4'h0;
         r_wdata     <= 32'h0;
         r_f3        <= 3'b000;
         r_off       <= 2'b00;
         r_cnt       <= 8'h0;
         r_bus_error <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         // Only a timeout transition lands in DONE with this set, so it is
         // visible for exactly the DONE cycle.
         r_bus_error <= w_timeout;
         if (w_accept) begin
            r_we    <= MemWrite;
            r_addr  <= {ALUResult[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_f3    <= Funct3;
            r_off   <= w_off;
            r_cnt   <= 8'h0;
         end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if ((r_state == S_WAIT) && bus_rvalid) begin
            r_read_data <= w_load_data;
         end
      end
   end

   // bus_req decodes straight from the state register so an asynchronous
   // reset withdraws it immediately.
   assign bus_req     = (r_state == S_REQ);
   assign bus_we      = r_we;
   assign bus_addr    = r_addr;
   assign bus_be      = r_be;
   assign bus_wdata   = r_wdata;
   assign ReadData    = r_read_data;
   assign BusError    = r_bus_error;
   assign AccessFault = (r_state == S_IDLE) && w_access && w_fault_cond;
   assign Stall       = w_access && !AccessFault && (r_state != S_DONE);

endmodule
